// File: rtl/clock_enable_pkg.sv
// Shared types and constants for the clock-enable sequencer.
// Contents: default widths, the sequencer state type, reset defaults and an
// exponent clamp helper.
package clock_enable_pkg;

  localparam int MAX_EXP_DEF = 16;
  localparam int CNT_W_DEF   = 16;
  localparam int EXP_W       = $clog2(MAX_EXP_DEF + 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } seq_state_t;

  localparam logic [EXP_W-1:0] DEFAULT_EXP   = EXP_W'(1);
  localparam int               DEFAULT_COUNT = 0;

  // Exponents above the supported maximum saturate to the maximum.
  function automatic logic [EXP_W-1:0] clamp_exp(input logic [EXP_W-1:0] e,
                                                 input int max_exp);
    if (int'(e) > max_exp) return EXP_W'(max_exp);
    return e;
  endfunction

endpackage

// File: rtl/clock_enable_sequencer_tick_counter.sv
// Free-running ratio counter with mask compare.
// Ports:
//   clk_in, rst : clock, synchronous active-high reset
//   clear       : zero the counter at this edge
//   en          : count this cycle; also qualifies the registered tick
//   exp         : ratio exponent (already clamped to MAX_EXP)
//   tick        : registered one-cycle pulse when the masked count wraps
//   div_clk     : counter bit exp-1, or tick when exp==0 (ungated)
//   wrap        : the next increment wraps the masked count (tick at next edge)
module tick_counter
  import clock_enable_pkg::*;
#(
  parameter int MAX_EXP = MAX_EXP_DEF
) (
  input  logic             clk_in,
  input  logic             rst,
  input  logic             clear,
  input  logic             en,
  input  logic [EXP_W-1:0] exp,
  output logic             tick,
  output logic             div_clk,
  output logic             wrap
);

  logic [MAX_EXP-1:0] count;
  logic [MAX_EXP-1:0] count_inc;
  logic [MAX_EXP-1:0] mask;
  logic [MAX_EXP-1:0] half;

  always_comb begin
    mask = '0;
    for (int unsigned i = 0; i < MAX_EXP; i++) begin
      mask[i] = (i < 32'(exp));
    end
  end

  assign count_inc = count + MAX_EXP'(1);
  assign wrap      = ((count_inc & mask) == '0);
  // Top bit of the mask selects counter[exp-1] without a variable index.
  assign half      = mask ^ (mask >> 1);
  assign div_clk   = (exp == '0) ? tick : |(count & half);

  // Clearing together with en still lets a wrap raise tick: this is how a
  // pending ratio is applied on the very edge that issues the tick.
  always_ff @(posedge clk_in) begin
    if (rst) begin
      count <= '0;
      tick  <= 1'b0;
    end else begin
      tick <= en & wrap;
      if (clear)   count <= '0;
      else if (en) count <= count_inc;
    end
  end

endmodule

// File: rtl/clock_enable_sequencer.sv
// Runtime-programmable clock-enable generator and burst sequencer.
// Ports:
//   clk_in, rst            : clock, synchronous active-high reset
//   cfg_valid/cfg_ready    : config handshake; cfg_exp (ratio 2**exp), cfg_count
//                            (burst ticks, 0 = free-run)
//   start, stop            : begin (from IDLE) / abort sequencing
//   tick                   : one-cycle enable every 2**exp RUN cycles
//   div_clk                : divided square wave, low outside RUN
//   busy, done             : RUN indicator / one-cycle burst-complete pulse
//   ticks_left             : remaining burst ticks
module clock_enable_sequencer
  import clock_enable_pkg::*;
#(
  parameter int MAX_EXP = MAX_EXP_DEF,
  parameter int CNT_W   = CNT_W_DEF
) (
  input  logic             clk_in,
  input  logic             rst,
  input  logic             cfg_valid,
  output logic             cfg_ready,
  input  logic [EXP_W-1:0] cfg_exp,
  input  logic [CNT_W-1:0] cfg_count,
  input  logic             start,
  input  logic             stop,
  output logic             tick,
  output logic             div_clk,
  output logic             busy,
  output logic             done,
  output logic [CNT_W-1:0] ticks_left
);

  seq_state_t       state, state_nx;
  logic [EXP_W-1:0] exp_r, pend_exp, cfg_exp_c;
  logic [CNT_W-1:0] count_r, pend_count, left_r;
  logic             pend_valid, cfg_fire, burst, last_tick;
  logic             clear, en, wrap, div_raw;

  assign cfg_exp_c = clamp_exp(cfg_exp, MAX_EXP);
  assign cfg_fire  = cfg_valid & cfg_ready;
  assign burst     = (count_r != '0);
  assign last_tick = burst & tick & (left_r == '0);

  assign busy       = (state == RUN);
  assign done       = (state == DONE);
  assign div_clk    = busy & div_raw;
  assign ticks_left = left_r;

  tick_counter #(.MAX_EXP(MAX_EXP)) u_tick_counter (
    .clk_in  (clk_in),
    .rst     (rst),
    .clear   (clear),
    .en      (en),
    .exp     (exp_r),
    .tick    (tick),
    .div_clk (div_raw),
    .wrap    (wrap)
  );

  always_ff @(posedge clk_in) begin
    if (rst) state <= IDLE;
    else     state <= state_nx;
  end

  // en is withheld in the final-tick cycle so an exp=0 burst cannot emit an
  // extra tick while moving to DONE.
  always_comb begin
    state_nx  = state;
    cfg_ready = 1'b1;
    clear     = 1'b0;
    en        = 1'b0;
    unique case (state)
      IDLE: begin
        if (start && !stop) begin
          state_nx = RUN;
          clear    = 1'b1;
        end
      end
      RUN: begin
        cfg_ready = ~pend_valid;
        if (stop) begin
          state_nx = IDLE;
          clear    = 1'b1;
        end else if (last_tick) begin
          state_nx = DONE;
        end else begin
          en    = 1'b1;
          clear = wrap & pend_valid;
        end
      end
      DONE:    state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk_in) begin
    if (rst) begin
      exp_r      <= DEFAULT_EXP;
      count_r    <= CNT_W'(DEFAULT_COUNT);
      left_r     <= '0;
      pend_valid <= 1'b0;
      pend_exp   <= '0;
      pend_count <= '0;
    end else begin
      unique case (state)
        IDLE: begin
          if (cfg_fire) begin
            exp_r   <= cfg_exp_c;
            count_r <= cfg_count;
          end
          if (start && !stop) left_r <= cfg_fire ? cfg_count : count_r;
        end
        RUN: begin
          if (stop) begin
            pend_valid <= 1'b0;
          end else if (last_tick) begin
            // Config arriving at burst end becomes the idle configuration.
            if (cfg_fire) begin
              exp_r   <= cfg_exp_c;
              count_r <= cfg_count;
            end else if (pend_valid) begin
              exp_r   <= pend_exp;
              count_r <= pend_count;
            end
            pend_valid <= 1'b0;
          end else begin
            if (wrap && pend_valid) begin
              exp_r      <= pend_exp;
              count_r    <= pend_count;
              left_r     <= pend_count;
              pend_valid <= 1'b0;
            end else if (wrap && burst && (left_r != '0)) begin
              left_r <= left_r - CNT_W'(1);
            end
            if (cfg_fire) begin
              pend_valid <= 1'b1;
              pend_exp   <= cfg_exp_c;
              pend_count <= cfg_count;
            end
          end
        end
        DONE: begin
          if (cfg_fire) begin
            exp_r   <= cfg_exp_c;
            count_r <= cfg_count;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_clock_enable_sequencer.sv
// Self-checking bench for clock_enable_sequencer: burst table, directed
// corner sequences and randomized stimulus against a phase-based model.
module tb_clock_enable_sequencer;

  localparam int MAX_EXP = 16;
  localparam int CNT_W   = 16;
  localparam int EXP_W   = 5;

  logic             clk_in = 1'b0;
  logic             rst, cfg_valid, cfg_ready, start, stop;
  logic             tick, div_clk, busy, done;
  logic [EXP_W-1:0] cfg_exp;
  logic [CNT_W-1:0] cfg_count, ticks_left;

  int n_checks = 0;
  int n_fail   = 0;

  clock_enable_sequencer #(.MAX_EXP(MAX_EXP), .CNT_W(CNT_W)) dut (
    .clk_in     (clk_in),
    .rst        (rst),
    .cfg_valid  (cfg_valid),
    .cfg_ready  (cfg_ready),
    .cfg_exp    (cfg_exp),
    .cfg_count  (cfg_count),
    .start      (start),
    .stop       (stop),
    .tick       (tick),
    .div_clk    (div_clk),
    .busy       (busy),
    .done       (done),
    .ticks_left (ticks_left)
  );

  always #5 clk_in = ~clk_in;

  task automatic cyc();
    @(posedge clk_in);
    #1;
  endtask

  task automatic check_val(input string name, input logic [31:0] act, input logic [31:0] req);
    n_checks++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", name, act, req);
    end
  endtask

  task automatic check_bit(input string name, input logic act, input logic req);
    n_checks++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %b, expected %b", name, act, req);
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    check_bit({tag, "_tick"}, tick, 1'b0);
    check_bit({tag, "_div"}, div_clk, 1'b0);
    check_bit({tag, "_busy"}, busy, 1'b0);
    check_bit({tag, "_done"}, done, 1'b0);
    check_val({tag, "_left"}, 32'(ticks_left), 32'd0);
    check_bit({tag, "_ready"}, cfg_ready, 1'b1);
  endtask

  // Reference model: tracks RUN phase (edges since start or last ratio
  // change); ticks land where phase is a multiple of 2**exp.
  int m_mode, m_exp, m_count, m_left, m_pend, p_exp, p_count, m_ph, m_tick;

  task automatic model_reset();
    m_mode = 0; m_exp = 1; m_count = 0; m_left = 0;
    m_pend = 0; p_exp = 0; p_count = 0; m_ph = 0; m_tick = 0;
  endtask

  task automatic model_step(input int r, input int st, input int sp, input int v,
                            input int ce_in, input int cc);
    int ce, rdy, acc, per, fin;
    ce  = (ce_in > MAX_EXP) ? MAX_EXP : ce_in;
    rdy = (m_mode != 1 || m_pend == 0) ? 1 : 0;
    acc = (v != 0 && rdy != 0) ? 1 : 0;
    if (r != 0) begin
      model_reset();
      return;
    end
    case (m_mode)
      0: begin
        if (acc != 0) begin m_exp = ce; m_count = cc; end
        if (st != 0 && sp == 0) begin m_mode = 1; m_ph = 0; m_left = m_count; end
        m_tick = 0;
      end
      2: begin
        if (acc != 0) begin m_exp = ce; m_count = cc; end
        m_mode = 0;
        m_tick = 0;
      end
      default: begin
        fin = (m_count != 0 && m_tick == 1 && m_left == 0) ? 1 : 0;
        if (sp != 0) begin
          m_mode = 0; m_pend = 0; m_tick = 0;
        end else if (fin != 0) begin
          m_mode = 2; m_tick = 0;
          if (acc != 0) begin m_exp = ce; m_count = cc; end
          else if (m_pend != 0) begin m_exp = p_exp; m_count = p_count; end
          m_pend = 0;
        end else begin
          m_ph++;
          per = 1 << m_exp;
          m_tick = ((m_ph % per) == 0) ? 1 : 0;
          if (m_tick != 0) begin
            if (m_pend != 0) begin
              m_exp = p_exp; m_count = p_count; m_left = p_count; m_ph = 0; m_pend = 0;
            end else if (m_count != 0 && m_left > 0) begin
              m_left--;
            end
          end
          if (acc != 0) begin m_pend = 1; p_exp = ce; p_count = cc; end
        end
      end
    endcase
  endtask

  function automatic int model_div();
    int per;
    per = 1 << m_exp;
    if (m_mode != 1) return 0;
    if (m_exp == 0) return m_tick;
    return ((m_ph % per) >= per / 2) ? 1 : 0;
  endfunction

  typedef struct {
    int exp_in;
    int cnt_in;
    int first_tick;
    int n_ticks;
    int done_at;
  } vec_t;

  vec_t vecs[6];

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail + 1);
    $fatal(1, "watchdog");
  end

  initial begin
    int first, seen, done_j, first_div, div_at_tick;
    int r_rst, r_start, r_stop, r_valid, r_exp, r_cnt;

    vecs[0] = '{exp_in: 2, cnt_in: 3, first_tick: 4,  n_ticks: 3, done_at: 13};
    vecs[1] = '{exp_in: 0, cnt_in: 1, first_tick: 1,  n_ticks: 1, done_at: 2};
    vecs[2] = '{exp_in: 1, cnt_in: 2, first_tick: 2,  n_ticks: 2, done_at: 5};
    vecs[3] = '{exp_in: 3, cnt_in: 1, first_tick: 8,  n_ticks: 1, done_at: 9};
    vecs[4] = '{exp_in: 0, cnt_in: 4, first_tick: 1,  n_ticks: 4, done_at: 5};
    vecs[5] = '{exp_in: 4, cnt_in: 2, first_tick: 16, n_ticks: 2, done_at: 33};

    rst = 1'b1; cfg_valid = 1'b0; cfg_exp = '0; cfg_count = '0; start = 1'b0; stop = 1'b0;
    cyc();
    cyc();
    check_reset_outputs("reset");
    rst = 1'b0;
    cyc();
    check_reset_outputs("idle");

    // Burst table: config offered in the same cycle as start.
    for (int v = 0; v < 6; v++) begin
      cfg_valid = 1'b1;
      cfg_exp   = EXP_W'(vecs[v].exp_in);
      cfg_count = CNT_W'(vecs[v].cnt_in);
      start     = 1'b1;
      cyc();
      cfg_valid = 1'b0;
      start     = 1'b0;
      check_bit("tbl_busy", busy, 1'b1);
      check_val("tbl_left_start", 32'(ticks_left), 32'(vecs[v].cnt_in));
      first = 0; seen = 0; done_j = 0;
      for (int j = 1; j <= 200 && done_j == 0; j++) begin
        cyc();
        if (tick === 1'b1) begin
          seen++;
          if (first == 0) first = j;
          check_val("tbl_left_tick", 32'(ticks_left), 32'(vecs[v].cnt_in - seen));
        end
        if (done === 1'b1) done_j = j;
      end
      check_val("tbl_first_tick", 32'(first), 32'(vecs[v].first_tick));
      check_val("tbl_n_ticks", 32'(seen), 32'(vecs[v].n_ticks));
      check_val("tbl_done_at", 32'(done_j), 32'(vecs[v].done_at));
      cyc();
      check_bit("tbl_done_one_cycle", done, 1'b0);
      check_bit("tbl_busy_after", busy, 1'b0);
    end

    // Free-run exp=0, then stop.
    cfg_valid = 1'b1; cfg_exp = 5'd0; cfg_count = 16'd0; start = 1'b1;
    cyc();
    cfg_valid = 1'b0; start = 1'b0;
    for (int j = 1; j <= 10; j++) begin
      cyc();
      check_bit("free_tick", tick, 1'b1);
      check_bit("free_div", div_clk, 1'b1);
      check_val("free_left", 32'(ticks_left), 32'd0);
    end
    stop = 1'b1;
    cyc();
    stop = 1'b0;
    check_bit("free_stop_tick", tick, 1'b0);
    check_bit("free_stop_busy", busy, 1'b0);
    check_bit("free_stop_div", div_clk, 1'b0);
    check_bit("free_stop_done", done, 1'b0);
    repeat (3) cyc();
    check_bit("free_no_done", done, 1'b0);

    // Pending ratio change: exp 3 -> 1 applied on the next tick.
    cfg_valid = 1'b1; cfg_exp = 5'd3; cfg_count = 16'd0; start = 1'b1;
    cyc();
    cfg_valid = 1'b0; start = 1'b0;
    repeat (3) cyc();
    check_bit("pend_no_tick_early", tick, 1'b0);
    cfg_valid = 1'b1; cfg_exp = 5'd1; cfg_count = 16'd0;
    check_bit("pend_ready_before", cfg_ready, 1'b1);
    cyc();
    check_bit("pend_ready_full", cfg_ready, 1'b0);
    check_bit("pend_tick_k4", tick, 1'b0);
    cyc();
    cfg_valid = 1'b0;
    check_bit("pend_ready_k5", cfg_ready, 1'b0);
    for (int j = 6; j <= 8; j++) begin
      cyc();
      check_bit("pend_old_period_tick", tick, (j == 8));
      check_bit("pend_ready_release", cfg_ready, (j == 8));
    end
    for (int j = 9; j <= 14; j++) begin
      cyc();
      check_bit("pend_new_period_tick", tick, ((j % 2) == 0));
      check_bit("pend_ready_empty", cfg_ready, 1'b1);
    end
    stop = 1'b1;
    cyc();
    stop = 1'b0;

    // Single-tick burst aborted in its tick cycle.
    cfg_valid = 1'b1; cfg_exp = 5'd1; cfg_count = 16'd1; start = 1'b1;
    cyc();
    cfg_valid = 1'b0; start = 1'b0;
    cyc();
    check_bit("one_no_tick_yet", tick, 1'b0);
    cyc();
    check_bit("one_tick", tick, 1'b1);
    check_val("one_left", 32'(ticks_left), 32'd0);
    stop = 1'b1;
    cyc();
    stop = 1'b0;
    check_bit("one_stop_tick", tick, 1'b0);
    check_bit("one_stop_done", done, 1'b0);
    check_bit("one_stop_busy", busy, 1'b0);
    cyc();
    check_bit("one_still_no_done", done, 1'b0);

    // Reset mid-burst, then start with reset defaults (exp=1, free-run).
    cfg_valid = 1'b1; cfg_exp = 5'd2; cfg_count = 16'd4; start = 1'b1;
    cyc();
    cfg_valid = 1'b0; start = 1'b0;
    repeat (8) cyc();
    check_val("rst_mid_left", 32'(ticks_left), 32'd2);
    cyc();
    rst = 1'b1;
    cyc();
    rst = 1'b0;
    check_reset_outputs("rst_mid");
    start = 1'b1;
    cyc();
    start = 1'b0;
    check_bit("rst_restart_busy", busy, 1'b1);
    for (int j = 1; j <= 6; j++) begin
      cyc();
      check_bit("rst_restart_tick", tick, ((j % 2) == 0));
      check_bit("rst_restart_div", div_clk, ((j % 2) == 1));
      check_val("rst_restart_left", 32'(ticks_left), 32'd0);
    end
    stop = 1'b1;
    cyc();
    stop = 1'b0;

    // Clamp: exp 31 behaves as 16.
    cfg_valid = 1'b1; cfg_exp = 5'd31; cfg_count = 16'd0; start = 1'b1;
    cyc();
    cfg_valid = 1'b0; start = 1'b0;
    first_div = 0; first = 0; seen = 0; div_at_tick = 1;
    for (int j = 1; j <= 65540; j++) begin
      cyc();
      if (div_clk === 1'b1 && first_div == 0) first_div = j;
      if (tick === 1'b1) begin
        seen++;
        if (first == 0) begin
          first = j;
          div_at_tick = (div_clk === 1'b1) ? 1 : 0;
        end
      end
    end
    check_val("clamp_div_rise", 32'(first_div), 32'd32768);
    check_val("clamp_first_tick", 32'(first), 32'd65536);
    check_val("clamp_n_ticks", 32'(seen), 32'd1);
    check_val("clamp_div_fall", 32'(div_at_tick), 32'd0);
    stop = 1'b1;
    cyc();
    stop = 1'b0;

    // Randomized stimulus against the model.
    rst = 1'b1;
    cyc();
    rst = 1'b0;
    model_reset();
    for (int n = 0; n < 3000; n++) begin
      r_rst   = ($urandom_range(0, 199) == 0) ? 1 : 0;
      r_start = ($urandom_range(0, 9) == 0) ? 1 : 0;
      r_stop  = ($urandom_range(0, 29) == 0) ? 1 : 0;
      r_valid = ($urandom_range(0, 5) == 0) ? 1 : 0;
      r_exp   = ($urandom_range(0, 19) == 0) ? int'($urandom_range(17, 31))
                                              : int'($urandom_range(0, 4));
      r_cnt   = int'($urandom_range(0, 4));
      rst       = (r_rst != 0);
      start     = (r_start != 0);
      stop      = (r_stop != 0);
      cfg_valid = (r_valid != 0);
      cfg_exp   = EXP_W'(r_exp);
      cfg_count = CNT_W'(r_cnt);
      cyc();
      model_step(r_rst, r_start, r_stop, r_valid, r_exp, r_cnt);
      check_bit("rnd_tick", tick, (m_tick != 0));
      check_bit("rnd_div", div_clk, (model_div() != 0));
      check_bit("rnd_busy", busy, (m_mode == 1));
      check_bit("rnd_done", done, (m_mode == 2));
      check_val("rnd_left", 32'(ticks_left), 32'(m_left));
      check_bit("rnd_ready", cfg_ready, (m_mode != 1 || m_pend == 0));
    end
    rst = 1'b0; start = 1'b0; stop = 1'b0; cfg_valid = 1'b0;

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
